// File: rtl/fifo_wr_pkg.sv
// Shared types and configuration checks for the FIFO write-side packetizer.
package fifo_wr_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } wr_state_t;

  // A packet admitted below half-full can only be guaranteed to fit if it is no longer than half the FIFO.
  function automatic bit max_pkt_ok(input int max_pkt, input int fifo_depth);
    return (max_pkt > 0) && (max_pkt <= fifo_depth / 2);
  endfunction

endpackage

// File: rtl/wr_skid_buf.sv
// Two-entry skid buffer. Ready is derived only from occupancy flops,
// so an accepted beat is presented at the head no earlier than the next cycle.
module wr_skid_buf #(
  parameter int WIDTH = 8
) (
  input  logic             wclk,
  input  logic             wrst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_pop_i,
  output logic [WIDTH-1:0] out_data_o
);

  logic [1:0]       occ_q, occ_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic             push, pop;

  assign in_ready_o  = (occ_q != 2'd2);
  assign out_valid_o = (occ_q != 2'd0);
  assign out_data_o  = head_q;
  assign push        = in_valid_i && in_ready_o;
  assign pop         = out_pop_i && out_valid_o;

  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    tail_d = tail_q;
    case ({push, pop})
      2'b10: begin
        if (occ_q == 2'd0) head_d = in_data_i;
        else               tail_d = in_data_i;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b11: begin
        // Occupancy stays put; the incoming beat lands behind whatever remains.
        if (occ_q == 2'd1) begin
          head_d = in_data_i;
        end else begin
          head_d = tail_q;
          tail_d = in_data_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      occ_q  <= 2'd0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      occ_q  <= occ_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

endmodule

// File: rtl/fifo_wr_packetizer.sv
// Write-side front end of the asynchronous FIFO: admits whole packets only when they
// are guaranteed to fit, frames beats as {last, data}, and keeps write statistics.
module fifo_wr_packetizer
  import fifo_wr_pkg::*;
#(
  parameter int DATA_WIDTH = 7,
  parameter int FIFO_DEPTH = 512,
  parameter int MAX_PKT    = 256,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  wclk,
  input  logic                  wrst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_last,
  output logic                  fifo_w_en,
  output logic [DATA_WIDTH:0]   fifo_wdata,
  input  logic                  fifo_full,
  input  logic                  fifo_half_full,
  input  logic                  fifo_wr_error,
  input  logic                  stats_clr,
  output logic [CNT_WIDTH-1:0]  pkt_cnt,
  output logic [CNT_WIDTH-1:0]  beat_cnt,
  output logic [CNT_WIDTH-1:0]  stall_cnt,
  output logic                  err_wr,
  output logic                  err_oversize
);

  localparam int BIP_W = $clog2(MAX_PKT + 1);

  if (!max_pkt_ok(MAX_PKT, FIFO_DEPTH)) begin : g_bad_cfg
    $error("fifo_wr_packetizer: MAX_PKT must be in 1..FIFO_DEPTH/2");
  end

  wr_state_t             state_q;
  logic [BIP_W-1:0]      bip_q;
  logic [CNT_WIDTH-1:0]  pkt_q, beat_q, stall_q;
  logic                  err_wr_q, err_ovs_q;

  logic                  head_valid;
  logic [DATA_WIDTH:0]   head_word;
  logic                  head_last;
  logic                  start, wr_ok, wr, stall;

  wr_skid_buf #(
    .WIDTH (DATA_WIDTH + 1)
  ) u_skid (
    .wclk        (wclk),
    .wrst_n      (wrst_n),
    .in_valid_i  (s_valid),
    .in_ready_o  (s_ready),
    .in_data_i   ({s_last, s_data}),
    .out_valid_o (head_valid),
    .out_pop_i   (wr),
    .out_data_o  (head_word)
  );

  assign head_last = head_word[DATA_WIDTH];
  // Half-full only gates packet starts; once streaming, only a truly full FIFO holds us.
  assign start     = (state_q == IDLE) && !fifo_half_full;
  assign wr_ok     = (state_q == STREAM) || start;
  assign wr        = head_valid && !fifo_full && wr_ok;
  assign stall     = head_valid && fifo_full && wr_ok;

  assign fifo_w_en    = wr;
  assign fifo_wdata   = head_word;
  assign pkt_cnt      = pkt_q;
  assign beat_cnt     = beat_q;
  assign stall_cnt    = stall_q;
  assign err_wr       = err_wr_q;
  assign err_oversize = err_ovs_q;

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q   <= IDLE;
      bip_q     <= '0;
      pkt_q     <= '0;
      beat_q    <= '0;
      stall_q   <= '0;
      err_wr_q  <= 1'b0;
      err_ovs_q <= 1'b0;
    end else begin
      if (wr) begin
        state_q <= head_last ? IDLE : STREAM;
        if (head_last)                      bip_q <= '0;
        else if (bip_q != BIP_W'(MAX_PKT))  bip_q <= bip_q + 1'b1;
      end
      if (stats_clr) begin
        pkt_q     <= '0;
        beat_q    <= '0;
        stall_q   <= '0;
        err_wr_q  <= 1'b0;
        err_ovs_q <= 1'b0;
      end else begin
        if (wr && (beat_q != '1))              beat_q  <= beat_q + 1'b1;
        if (wr && head_last && (pkt_q != '1))  pkt_q   <= pkt_q + 1'b1;
        if (stall && (stall_q != '1))          stall_q <= stall_q + 1'b1;
        if (fifo_wr_error)                     err_wr_q <= 1'b1;
        // bip_q counts beats already written, so this fires on beat MAX_PKT of a packet that goes on.
        if (wr && !head_last && (bip_q >= BIP_W'(MAX_PKT - 1))) err_ovs_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_wr_packetizer.sv
// Directed bench for fifo_wr_packetizer: per-scenario tasks with hand-computed expectations.
module tb_fifo_wr_packetizer;

  localparam int DW = 7;
  localparam int CW = 16;

  logic          wclk = 1'b0;
  logic          wrst_n = 1'b1;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_data = '0;
  logic          s_last = 1'b0;
  logic          fifo_w_en;
  logic [DW:0]   fifo_wdata;
  logic          fifo_full = 1'b0;
  logic          fifo_half_full = 1'b0;
  logic          fifo_wr_error = 1'b0;
  logic          stats_clr = 1'b0;
  logic [CW-1:0] pkt_cnt, beat_cnt, stall_cnt;
  logic          err_wr, err_oversize;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW:0] src_q[$];
  logic [DW:0] wr_q[$];
  bit          wen_seen;

  always #5 wclk = ~wclk;

  fifo_wr_packetizer #(
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (512),
    .MAX_PKT    (256),
    .CNT_WIDTH  (CW)
  ) dut (
    .wclk           (wclk),
    .wrst_n         (wrst_n),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .s_data         (s_data),
    .s_last         (s_last),
    .fifo_w_en      (fifo_w_en),
    .fifo_wdata     (fifo_wdata),
    .fifo_full      (fifo_full),
    .fifo_half_full (fifo_half_full),
    .fifo_wr_error  (fifo_wr_error),
    .stats_clr      (stats_clr),
    .pkt_cnt        (pkt_cnt),
    .beat_cnt       (beat_cnt),
    .stall_cnt      (stall_cnt),
    .err_wr         (err_wr),
    .err_oversize   (err_oversize)
  );

  // One clock: called just after a negedge, observes 1ns before the posedge, returns at the next negedge.
  task automatic cycle();
    if (src_q.size() > 0) begin
      s_valid = 1'b1;
      {s_last, s_data} = src_q[0];
    end else begin
      s_valid = 1'b0;
      s_last  = 1'b0;
      s_data  = '0;
    end
    #4;
    wen_seen = fifo_w_en;
    if (fifo_w_en) wr_q.push_back(fifo_wdata);
    if (s_valid && s_ready) void'(src_q.pop_front());
    @(negedge wclk);
  endtask

  task automatic run_until(input int n, input int budget, output bit ok);
    int k = 0;
    while (wr_q.size() < n && k < budget) begin
      cycle();
      k++;
    end
    ok = (wr_q.size() >= n);
  endtask

  task automatic clr_stats();
    stats_clr = 1'b1;
    cycle();
    stats_clr = 1'b0;
  endtask

  task automatic test_reset();
    wrst_n = 1'b0;
    repeat (2) @(negedge wclk);
    n_tests++; if (s_ready !== 1'b1)   begin n_fail++; $display("FAIL reset_s_ready got %b want 1", s_ready); end
    n_tests++; if (fifo_w_en !== 1'b0) begin n_fail++; $display("FAIL reset_w_en got %b want 0", fifo_w_en); end
    n_tests++; if (fifo_wdata !== '0)  begin n_fail++; $display("FAIL reset_wdata got %h want 0", fifo_wdata); end
    n_tests++; if ({pkt_cnt, beat_cnt, stall_cnt} !== '0) begin
      n_fail++; $display("FAIL reset_counters got %0d/%0d/%0d want 0/0/0", pkt_cnt, beat_cnt, stall_cnt);
    end
    n_tests++; if ({err_wr, err_oversize} !== 2'b00) begin
      n_fail++; $display("FAIL reset_flags got %b%b want 00", err_wr, err_oversize);
    end
    wrst_n = 1'b1;
    @(negedge wclk);
  endtask

  task automatic test_single_pkt();
    bit ok;
    logic [DW:0] exp;
    wr_q.delete();
    clr_stats();
    for (int i = 0; i < 4; i++) src_q.push_back({i == 3, 7'(i + 1)});
    cycle();
    n_tests++; if (wr_q.size() != 0) begin n_fail++; $display("FAIL single_no_write_on_accept got %0d writes want 0", wr_q.size()); end
    cycle();
    n_tests++; if (wr_q.size() != 1) begin n_fail++; $display("FAIL single_first_write_latency got %0d writes want 1", wr_q.size()); end
    run_until(4, 20, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL single_timeout got %0d writes want 4", wr_q.size()); end
    for (int i = 0; i < 4; i++) begin
      exp = {i == 3, 7'(i + 1)};
      n_tests++;
      if (i >= wr_q.size() || wr_q[i] !== exp) begin
        n_fail++; $display("FAIL single_beat%0d got %h want %h", i, (i < wr_q.size()) ? wr_q[i] : 'x, exp);
      end
    end
    n_tests++; if (pkt_cnt !== 16'd1)  begin n_fail++; $display("FAIL single_pkt_cnt got %0d want 1", pkt_cnt); end
    n_tests++; if (beat_cnt !== 16'd4) begin n_fail++; $display("FAIL single_beat_cnt got %0d want 4", beat_cnt); end
  endtask

  task automatic test_half_full();
    bit ok;
    wr_q.delete();
    clr_stats();
    fifo_half_full = 1'b1;
    src_q.push_back({1'b0, 7'd10});
    src_q.push_back({1'b1, 7'd11});
    repeat (5) cycle();
    n_tests++; if (wr_q.size() != 0) begin n_fail++; $display("FAIL halffull_blocks_start got %0d writes want 0", wr_q.size()); end
    n_tests++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL halffull_skid_full_ready got %b want 0", s_ready); end
    fifo_half_full = 1'b0;
    cycle();
    n_tests++; if (wr_q.size() != 1 || wr_q[0] !== {1'b0, 7'd10}) begin
      n_fail++; $display("FAIL halffull_first_write got %0d writes want 1 of 0a", wr_q.size());
    end
    fifo_half_full = 1'b1;
    cycle();
    n_tests++; if (wr_q.size() != 2 || wr_q[1] !== {1'b1, 7'd11}) begin
      n_fail++; $display("FAIL halffull_stream_ignores got %0d writes want 2 ending 8b", wr_q.size());
    end
    fifo_half_full = 1'b0;
    run_until(2, 5, ok);
    n_tests++; if (pkt_cnt !== 16'd1 || beat_cnt !== 16'd2) begin
      n_fail++; $display("FAIL halffull_counts got %0d/%0d want 1/2", pkt_cnt, beat_cnt);
    end
  endtask

  task automatic test_full_stall();
    bit ok;
    int w_during;
    logic [DW:0] exp;
    wr_q.delete();
    clr_stats();
    for (int i = 0; i < 8; i++) src_q.push_back({i == 7, 7'(20 + i)});
    run_until(3, 10, ok);
    fifo_full = 1'b1;
    w_during = 0;
    repeat (3) begin
      cycle();
      if (wen_seen) w_during++;
    end
    fifo_full = 1'b0;
    n_tests++; if (w_during != 0) begin n_fail++; $display("FAIL full_no_writes got %0d want 0", w_during); end
    run_until(8, 20, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL full_timeout got %0d writes want 8", wr_q.size()); end
    for (int i = 0; i < 8; i++) begin
      exp = {i == 7, 7'(20 + i)};
      n_tests++;
      if (i >= wr_q.size() || wr_q[i] !== exp) begin
        n_fail++; $display("FAIL full_beat%0d got %h want %h", i, (i < wr_q.size()) ? wr_q[i] : 'x, exp);
      end
    end
    n_tests++; if (stall_cnt !== 16'd3) begin n_fail++; $display("FAIL full_stall_cnt got %0d want 3", stall_cnt); end
    n_tests++; if (pkt_cnt !== 16'd1 || beat_cnt !== 16'd8) begin
      n_fail++; $display("FAIL full_counts got %0d/%0d want 1/8", pkt_cnt, beat_cnt);
    end
  endtask

  task automatic test_oversize();
    int first_err = -1;
    int k = 0;
    int bad = 0;
    logic [DW:0] exp;
    wr_q.delete();
    clr_stats();
    for (int i = 0; i < 300; i++) src_q.push_back({i == 299, 7'(i)});
    while (wr_q.size() < 300 && k < 400) begin
      cycle();
      k++;
      if (err_oversize && first_err < 0) first_err = wr_q.size();
    end
    n_tests++; if (wr_q.size() != 300) begin n_fail++; $display("FAIL oversize_timeout got %0d writes want 300", wr_q.size()); end
    n_tests++; if (first_err != 256) begin n_fail++; $display("FAIL oversize_set_point got %0d want 256", first_err); end
    for (int i = 0; i < wr_q.size(); i++) begin
      exp = {i == 299, 7'(i)};
      if (wr_q[i] !== exp) bad++;
    end
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL oversize_data got %0d bad beats want 0", bad); end
    n_tests++; if (pkt_cnt !== 16'd1 || beat_cnt !== 16'd300) begin
      n_fail++; $display("FAIL oversize_counts got %0d/%0d want 1/300", pkt_cnt, beat_cnt);
    end
    clr_stats();
    n_tests++; if (err_oversize !== 1'b0) begin n_fail++; $display("FAIL oversize_clear got %b want 0", err_oversize); end
  endtask

  task automatic test_clr_same_cycle();
    bit ok;
    wr_q.delete();
    clr_stats();
    src_q.push_back({1'b0, 7'd33});
    src_q.push_back({1'b1, 7'd34});
    run_until(1, 10, ok);
    stats_clr = 1'b1;
    cycle();
    stats_clr = 1'b0;
    n_tests++; if (!wen_seen || wr_q.size() != 2 || wr_q[1] !== {1'b1, 7'd34}) begin
      n_fail++; $display("FAIL clr_last_write got %0d writes want 2 ending a2", wr_q.size());
    end
    n_tests++; if (pkt_cnt !== 16'd0 || beat_cnt !== 16'd0) begin
      n_fail++; $display("FAIL clr_priority got %0d/%0d want 0/0", pkt_cnt, beat_cnt);
    end
    // A 1-beat packet leaves the FSM in IDLE, so half-full must block the next one.
    src_q.push_back({1'b1, 7'd35});
    run_until(3, 10, ok);
    fifo_half_full = 1'b1;
    src_q.push_back({1'b1, 7'd36});
    repeat (3) cycle();
    n_tests++; if (wr_q.size() != 3) begin n_fail++; $display("FAIL clr_onebeat_idle got %0d writes want 3", wr_q.size()); end
    fifo_half_full = 1'b0;
    run_until(4, 10, ok);
    n_tests++; if (pkt_cnt !== 16'd2 || beat_cnt !== 16'd2) begin
      n_fail++; $display("FAIL clr_resume_counts got %0d/%0d want 2/2", pkt_cnt, beat_cnt);
    end
  endtask

  task automatic test_wr_error();
    fifo_wr_error = 1'b1;
    cycle();
    fifo_wr_error = 1'b0;
    cycle();
    n_tests++; if (err_wr !== 1'b1) begin n_fail++; $display("FAIL wr_error_sticky got %b want 1", err_wr); end
    clr_stats();
    n_tests++; if (err_wr !== 1'b0) begin n_fail++; $display("FAIL wr_error_clear got %b want 0", err_wr); end
  endtask

  task automatic test_mid_reset();
    bit ok;
    logic [DW:0] exp;
    wr_q.delete();
    clr_stats();
    for (int i = 0; i < 6; i++) src_q.push_back({i == 5, 7'(40 + i)});
    run_until(3, 10, ok);
    src_q.delete();
    s_valid = 1'b0;
    wrst_n  = 1'b0;
    #1;
    n_tests++; if (s_ready !== 1'b1 || fifo_w_en !== 1'b0 || fifo_wdata !== '0) begin
      n_fail++; $display("FAIL midrst_port_state got ready=%b wen=%b wdata=%h want 1/0/00", s_ready, fifo_w_en, fifo_wdata);
    end
    n_tests++; if ({pkt_cnt, beat_cnt, stall_cnt, err_wr, err_oversize} !== '0) begin
      n_fail++; $display("FAIL midrst_stats got %0d/%0d/%0d/%b/%b want all 0", pkt_cnt, beat_cnt, stall_cnt, err_wr, err_oversize);
    end
    @(negedge wclk);
    wrst_n = 1'b1;
    wr_q.delete();
    fifo_half_full = 1'b1;
    for (int i = 0; i < 3; i++) src_q.push_back({i == 2, 7'(50 + i)});
    repeat (3) cycle();
    n_tests++; if (wr_q.size() != 0) begin n_fail++; $display("FAIL midrst_idle_after got %0d writes want 0", wr_q.size()); end
    fifo_half_full = 1'b0;
    run_until(3, 10, ok);
    for (int i = 0; i < 3; i++) begin
      exp = {i == 2, 7'(50 + i)};
      n_tests++;
      if (i >= wr_q.size() || wr_q[i] !== exp) begin
        n_fail++; $display("FAIL midrst_beat%0d got %h want %h", i, (i < wr_q.size()) ? wr_q[i] : 'x, exp);
      end
    end
    n_tests++; if (pkt_cnt !== 16'd1 || beat_cnt !== 16'd3) begin
      n_fail++; $display("FAIL midrst_counts got %0d/%0d want 1/3", pkt_cnt, beat_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single_pkt();
    test_half_full();
    test_full_stall();
    test_oversize();
    test_clr_same_cycle();
    test_wr_error();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end

endmodule
